// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : uart_pkg
//  Purpose : Shared types and constants for the UART frame receive path:
//            bit timing, frame-parser state encoding, error cause codes and
//            the default frame start marker.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package uart_pkg;

    // Receiver bit period in system clocks.
    localparam int BIT_CYC = 2604;

    // Frame parser states.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEN     = 3'd1,
        PAYLOAD = 3'd2,
        CSUM    = 3'd3,
        DRAIN   = 3'd4
    } state_t;

    // Error causes reported alongside frame_err.
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_CSUM = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    // Default frame start marker.
    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

endpackage
`default_nettype wire

// File: rtl/uart_frame_buf.sv
`default_nettype none
// ============================================================================
//  Module  : uart_frame_buf
//  Purpose : Payload holding buffer, DEPTH x 8 registers. Synchronous write,
//            combinational read. Contents are not reset.
//  Ports   : clk        - system clock
//            wr_en_i    - write strobe
//            wr_addr_i  - write index
//            wr_data_i  - write byte
//            rd_addr_i  - read index
//            rd_data_o  - byte at rd_addr_i (combinational)
//  Rev     : 1.0  initial release
// ============================================================================
module uart_frame_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [7:0]    wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [7:0]    rd_data_o
);

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule
`default_nettype wire

// File: rtl/uart_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module  : uart_frame_rx
//  Purpose : Frame parser behind the UART receiver. Finds SYNC/LEN/PAYLOAD/
//            CSUM frames in the byte strobe stream, validates length, XOR
//            checksum and inter-byte gap, then replays good payloads on a
//            valid/ready byte stream. Bad frames are dropped and reported.
//  Ports   : clk, rst       - clock, asynchronous active-high reset
//            rx_vld_i       - one-cycle byte strobe from the receiver
//            rx_data_i      - received byte
//            out_vld_o      - payload byte available
//            out_rdy_i      - sink ready
//            out_data_o     - payload byte
//            out_last_o     - final payload byte of the frame
//            frame_ok_o     - pulse: frame validated
//            frame_err_o    - pulse: frame rejected
//            err_code_o     - rejection cause (1 len, 2 csum, 3 timeout)
//            ovr_o          - pulse: byte dropped while draining
//  Rev     : 1.0  initial release
// ============================================================================
module uart_frame_rx
    import uart_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE   = DEF_SYNC_BYTE,
    parameter int         MAX_LEN     = 16,
    parameter int         TIMEOUT_CYC = 10 * BIT_CYC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_vld_i,
    input  logic [7:0] rx_data_i,
    output logic       out_vld_o,
    input  logic       out_rdy_i,
    output logic [7:0] out_data_o,
    output logic       out_last_o,
    output logic       frame_ok_o,
    output logic       frame_err_o,
    output logic [1:0] err_code_o,
    output logic       ovr_o
);

    localparam int         PTR_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int         GAP_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [8:0] MAX_LEN_V = 9'(MAX_LEN);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYC - 1);

    state_t             state_q;
    logic [7:0]         len_q;
    logic [7:0]         csum_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [GAP_W-1:0]   gap_cnt_q;

    logic [7:0]         len_m1;
    logic [PTR_W-1:0]   rd_ptr_d;
    logic [PTR_W-1:0]   rd_addr;
    logic [7:0]         rd_data;
    logic               buf_wr;
    logic               gap_active;
    logic               xfer;

    assign len_m1     = len_q - 8'd1;
    assign rd_ptr_d   = rd_ptr_q + 1'b1;
    // Output byte is registered, so the read port looks one entry ahead:
    // entry 0 while the checksum byte is judged, rd_ptr+1 while draining.
    assign rd_addr    = (state_q == DRAIN) ? rd_ptr_d : '0;
    assign buf_wr     = rx_vld_i && (state_q == PAYLOAD);
    assign gap_active = (state_q == LEN) || (state_q == PAYLOAD) || (state_q == CSUM);
    assign xfer       = out_vld_o && out_rdy_i;

    uart_frame_buf #(
        .DEPTH (MAX_LEN),
        .AW    (PTR_W)
    ) u_buf (
        .clk       (clk),
        .wr_en_i   (buf_wr),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (rx_data_i),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            csum_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            gap_cnt_q   <= '0;
            out_vld_o   <= 1'b0;
            out_data_o  <= '0;
            out_last_o  <= 1'b0;
            frame_ok_o  <= 1'b0;
            frame_err_o <= 1'b0;
            err_code_o  <= '0;
            ovr_o       <= 1'b0;
        end else begin
            frame_ok_o  <= 1'b0;
            frame_err_o <= 1'b0;
            ovr_o       <= 1'b0;

            // Gap timer; a byte in the same cycle takes priority and is
            // handled by the state case below.
            if (gap_active && !rx_vld_i) begin
                if (gap_cnt_q == GAP_LAST) begin
                    frame_err_o <= 1'b1;
                    err_code_o  <= ERR_TMO;
                    gap_cnt_q   <= '0;
                    state_q     <= IDLE;
                end else begin
                    gap_cnt_q <= gap_cnt_q + 1'b1;
                end
            end

            case (state_q)
                IDLE: begin
                    if (rx_vld_i && (rx_data_i == SYNC_BYTE)) begin
                        gap_cnt_q <= '0;
                        state_q   <= LEN;
                    end
                end
                LEN: begin
                    if (rx_vld_i) begin
                        len_q     <= rx_data_i;
                        csum_q    <= rx_data_i;
                        wr_ptr_q  <= '0;
                        gap_cnt_q <= '0;
                        if ((rx_data_i == 8'd0) || ({1'b0, rx_data_i} > MAX_LEN_V)) begin
                            frame_err_o <= 1'b1;
                            err_code_o  <= ERR_LEN;
                            state_q     <= IDLE;
                        end else begin
                            state_q <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (rx_vld_i) begin
                        csum_q    <= csum_q ^ rx_data_i;
                        wr_ptr_q  <= wr_ptr_q + 1'b1;
                        gap_cnt_q <= '0;
                        if (8'(wr_ptr_q) == len_m1) begin
                            state_q <= CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (rx_vld_i) begin
                        gap_cnt_q <= '0;
                        if (rx_data_i == csum_q) begin
                            frame_ok_o <= 1'b1;
                            out_vld_o  <= 1'b1;
                            out_data_o <= rd_data;
                            out_last_o <= (len_q == 8'd1);
                            rd_ptr_q   <= '0;
                            state_q    <= DRAIN;
                        end else begin
                            frame_err_o <= 1'b1;
                            err_code_o  <= ERR_CSUM;
                            state_q     <= IDLE;
                        end
                    end
                end
                DRAIN: begin
                    if (rx_vld_i) begin
                        ovr_o <= 1'b1;
                    end
                    if (xfer) begin
                        if (out_last_o) begin
                            out_vld_o  <= 1'b0;
                            out_last_o <= 1'b0;
                            state_q    <= IDLE;
                        end else begin
                            rd_ptr_q   <= rd_ptr_d;
                            out_data_o <= rd_data;
                            out_last_o <= (8'(rd_ptr_d) == len_m1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/uart_frame_rx.md
# uart_frame_rx

Byte-stream frame parser directly downstream of the UART receiver. Consumes the receiver's single-cycle `rx_vld`/`rx_data` byte strobes, locates frames of the form SYNC, LEN, PAYLOAD[LEN], CSUM, and checks length, checksum and inter-byte timeout. It buffers the payload internally and replays only validated payloads on a valid/ready byte stream to the command logic. Bad frames are dropped and reported on error strobes.

## Interface
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `MAX_LEN`, 16: maximum payload bytes, range 1..255; sets buffer depth.
- `TIMEOUT_CYC`, 26040: inter-byte gap limit in clk cycles, equal to 10 bit times at 2604 cycles/bit.
- `clk` in 1: system clock.
- `rst` in 1: reset. One clock; reset is asynchronous and active-high.
- `rx_vld` in 1: one-cycle strobe; `rx_data` is valid in that cycle.
- `rx_data` in 8: received byte.
- `out_vld` out 1: payload byte available.
- `out_rdy` in 1: sink accepts the byte; a transfer occurs when `out_vld & out_rdy`.
- `out_data` out 8: payload byte.
- `out_last` out 1: marks the final payload byte of the frame.
- `frame_ok` out 1: one-cycle pulse when a frame is validated.
- `frame_err` out 1: one-cycle pulse when a frame is rejected.
- `err_code` out 2: error cause, valid with `frame_err`. 1 = bad length, 2 = checksum, 3 = timeout.
- `ovr` out 1: one-cycle pulse when a byte is dropped during DRAIN.

## Operation
- States:
  - IDLE: bytes other than `SYNC_BYTE` are ignored silently. `SYNC_BYTE` moves to LEN.
  - LEN: the byte is stored as `len` and the checksum is set to `csum = byte`.
    - 0 or greater than `MAX_LEN`: error, code 1, go to IDLE.
    - Otherwise go to PAYLOAD with `wr_ptr = 0`.
  - PAYLOAD: each byte is written to `buf[wr_ptr]`, then `csum ^= byte` and `wr_ptr++`. When `wr_ptr == len-1` is written, go to CSUM.
  - CSUM: compare the byte with `csum`.
    - Equal: pulse `frame_ok`, go to DRAIN with `rd_ptr = 0`.
    - Not equal: error, code 2, go to IDLE.
  - DRAIN: `out_vld = 1`, `out_data = buf[rd_ptr]`, `out_last = (rd_ptr == len-1)`. On each transfer `rd_ptr++`. Transfer of the last byte returns to IDLE.
- Checksum: 8-bit XOR over LEN and all payload bytes. SYNC is not included.
- Timeout:
  - `gap_cnt` is active in LEN, PAYLOAD and CSUM. It clears on every accepted `rx_vld` and on entry to LEN.
  - When `gap_cnt == TIMEOUT_CYC-1` with no `rx_vld`: error, code 3, go to IDLE.
  - In the same cycle, `rx_vld` wins over timeout.
- In DRAIN, `rx_vld` bytes are discarded and `ovr` pulses. SYNC is not detected in DRAIN.
- The buffer is not cleared between frames. Stale contents are never output.
- Pointer widths are `$clog2(MAX_LEN)`. `len` is 8 bits. `gap_cnt` is `$clog2(TIMEOUT_CYC)` bits.

## Timing
- Reset values: `out_vld`, `out_last`, `frame_ok`, `frame_err`, `ovr` = 0; `out_data` = 0; `err_code` = 0; state IDLE; all counters 0. Reset mid-frame or mid-DRAIN aborts with no pulse.
- Each `rx_vld` is consumed in its own cycle. The next state is visible in the following cycle.
- CSUM byte accepted at cycle N: `frame_ok` = 1 and `out_vld` = 1 with byte 0 at N+1.
- `out_data`, `out_vld` and `out_last` are registered outputs. They hold stable while `out_rdy` = 0.
- With `out_rdy` held high, one byte transfers per cycle. Last transfer at cycle M: `out_vld` = 0 at M+1, and a SYNC at M+1 is accepted.
- `frame_err`, `err_code` and `ovr` are registered: they assert in the cycle after the cause. `err_code` holds its value until the next error.
- The error pulse and the return to IDLE occur in the same cycle. A SYNC arriving in that cycle starts a new frame.

## Structure
- Shared package `uart_pkg`:
  - `BIT_CYC` = 2604.
  - State enum: IDLE, LEN, PAYLOAD, CSUM, DRAIN.
  - Error code constants: `ERR_LEN` = 1, `ERR_CSUM` = 2, `ERR_TMO` = 3.
  - Default `SYNC_BYTE`.
- Sub-module `uart_frame_buf`: `MAX_LEN`×8 register array with a synchronous write port and a combinational read port. No reset on its contents.
- Top level holds the FSM, the checksum, the pointers, the gap counter and the output registers.

## Test plan
- Send A5 03 11 22 33 03 with `out_rdy` = 1 → `frame_ok` pulse; output 11, 22, 33 on consecutive cycles; `out_last` only with 33.
- Send A5 02 AA BB 00 (correct CSUM is 13) → `frame_err`, `err_code` = 2, no `out_vld`.
- Send A5 00, then A5 11 with `MAX_LEN` = 16 → two `frame_err` pulses, each with `err_code` = 1.
- Send A5 02 AA, then idle 26040 cycles → `frame_err` with code 3 exactly `TIMEOUT_CYC` cycles after AA. A following valid frame passes.
- Valid 3-byte frame with `out_rdy` = 0 for 50000 cycles while A5 01 7E 7F arrives → `ovr` pulses 4 times; data holds 11. After `out_rdy` = 1, output 11 22 33.
- Assert `rst` mid-PAYLOAD → all outputs 0, no pulses. Next valid frame A5 01 7E 7F → `frame_ok` and `out_data` = 7E with `out_last`.
